// File: rtl/hmac_mode_core.sv
// HMAC-384/512 mode wrapper around two iterative SHA-512 cores (inner H1, outer H2).
// Optional zeroize input is built when HMAC_ZEROIZE_EN is defined.

module sha512_core (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          init,
    input  logic          next,
    input  logic [1:0]    mode,
    input  logic          work_factor,
    input  logic [1023:0] block,
    output logic          ready,
    output logic [511:0]  digest
);
    localparam logic [63:0] K [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

    localparam logic [511:0] IV_384 = {
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
    localparam logic [511:0] IV_512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    logic [63:0]  r_h [8];
    logic [63:0]  r_v [8];
    logic [63:0]  r_w [16];
    logic         r_busy;
    logic [6:0]   r_round;
    logic [63:0]  w_k, w_t1, w_t2, w_wnew;
    logic [511:0] w_iv;
    logic [6:0]   w_last;

    always_comb begin
        w_k    = (r_round < 7'd80) ? K[r_round] : '0;
        w_t1   = r_v[7] + (rotr(r_v[4], 14) ^ rotr(r_v[4], 18) ^ rotr(r_v[4], 41))
               + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6])) + w_k + r_w[0];
        w_t2   = (rotr(r_v[0], 28) ^ rotr(r_v[0], 34) ^ rotr(r_v[0], 39))
               + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
        w_wnew = (rotr(r_w[14], 19) ^ rotr(r_w[14], 61) ^ (r_w[14] >> 6)) + r_w[9]
               + (rotr(r_w[1], 1) ^ rotr(r_w[1], 8) ^ (r_w[1] >> 7)) + r_w[0];
        w_iv   = (mode == 2'h3) ? IV_512 : IV_384;
        // work_factor pads the run with idle rounds so the result takes longer to appear
        w_last = work_factor ? 7'd127 : 7'd80;
    end

    // init/next restart the core even while busy, so an abandoned run is simply overwritten
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                r_h[i] <= '0;
                r_v[i] <= '0;
            end
            for (int unsigned i = 0; i < 16; i++) r_w[i] <= '0;
            r_busy  <= 1'b0;
            r_round <= '0;
        end else if (init || next) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (init) r_h[i] <= w_iv[511-64*i -: 64];
                r_v[i] <= init ? w_iv[511-64*i -: 64] : r_h[i];
            end
            for (int unsigned i = 0; i < 16; i++) r_w[i] <= block[1023-64*i -: 64];
            r_busy  <= 1'b1;
            r_round <= '0;
        end else if (r_busy) begin
            if (r_round < 7'd80) begin
                r_v[0] <= w_t1 + w_t2;
                r_v[1] <= r_v[0];
                r_v[2] <= r_v[1];
                r_v[3] <= r_v[2];
                r_v[4] <= r_v[3] + w_t1;
                r_v[5] <= r_v[4];
                r_v[6] <= r_v[5];
                r_v[7] <= r_v[6];
                for (int unsigned i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
                r_w[15] <= w_wnew;
            end
            if (r_round == w_last) begin
                for (int unsigned i = 0; i < 8; i++) r_h[i] <= r_h[i] + r_v[i];
                r_busy <= 1'b0;
            end else begin
                r_round <= r_round + 7'd1;
            end
        end
    end

    assign ready  = !r_busy;
    assign digest = {r_h[0], r_h[1], r_h[2], r_h[3], r_h[4], r_h[5], r_h[6], r_h[7]};
endmodule

module hmac_mode_core #(
    parameter int unsigned SUPPORT_512 = 1
) (
`ifdef HMAC_ZEROIZE_EN
    input  logic          zeroize,
`endif
    input  logic          clk,
    input  logic          reset_n,
    input  logic          init,
    input  logic          next,
    input  logic          mode,
    input  logic [511:0]  key,
    input  logic [1023:0] block,
    output logic          ready,
    output logic [511:0]  tag,
    output logic          tag_valid,
    output logic          error
);
    typedef enum logic [2:0] {IDLE, IPAD, OPAD, HMAC, DONE} state_t;

    state_t         r_state, r_prev_state;
    logic           r_mode, r_key_loaded, r_tag_valid, r_error;
    logic [511:0]   r_tag;
    logic           w_mode_in, w_first, w_h1_ready, w_h2_ready;
    logic [1:0]     w_sub_mode;
    logic [511:0]   w_key, w_h1_digest, w_h2_digest;
    logic [1023:0]  w_h1_block, w_h2_block, w_final;

    assign w_mode_in  = (SUPPORT_512 != 0) ? mode : 1'b0;
    assign w_first    = (r_state != r_prev_state);
    assign w_sub_mode = {1'b1, r_mode};
    assign w_key      = r_mode ? key : {key[511:128], 128'b0};
    assign w_final    = r_mode ? {w_h1_digest, 1'b1, 383'b0, 128'h600}
                               : {w_h1_digest[511:128], 1'b1, 511'b0, 128'h580};
    assign w_h1_block = (r_state == IPAD) ? ({w_key, 512'b0} ^ {128{8'h36}}) : block;
    assign w_h2_block = (r_state == OPAD) ? ({w_key, 512'b0} ^ {128{8'h5c}}) : w_final;

    sha512_core u_h1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .init        ((r_state == IPAD) && w_first),
        .next        ((r_state == OPAD) && w_first),
        .mode        (w_sub_mode),
        .work_factor (1'b0),
        .block       (w_h1_block),
        .ready       (w_h1_ready),
        .digest      (w_h1_digest)
    );

    sha512_core u_h2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .init        ((r_state == OPAD) && w_first),
        .next        ((r_state == HMAC) && w_first),
        .mode        (w_sub_mode),
        .work_factor (1'b0),
        .block       (w_h2_block),
        .ready       (w_h2_ready),
        .digest      (w_h2_digest)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_prev_state <= IDLE;
            r_mode       <= 1'b0;
            r_key_loaded <= 1'b0;
            r_tag        <= '0;
            r_tag_valid  <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_prev_state <= r_state;
            r_error      <= 1'b0;
`ifdef HMAC_ZEROIZE_EN
            if (zeroize) begin
                r_state      <= IDLE;
                r_tag        <= '0;
                r_tag_valid  <= 1'b0;
                r_key_loaded <= 1'b0;
            end else
`endif
            begin
                // sub-core ready is only trusted from the second cycle, after the pulse has landed
                case (r_state)
                    IDLE: begin
                        if (init) begin
                            r_state      <= IPAD;
                            r_mode       <= w_mode_in;
                            r_key_loaded <= 1'b1;
                            r_tag_valid  <= 1'b0;
                        end else if (next) begin
                            if (r_key_loaded) begin
                                r_state     <= OPAD;
                                r_tag_valid <= 1'b0;
                            end else begin
                                r_error <= 1'b1;
                            end
                        end
                    end
                    IPAD: if (!w_first && w_h1_ready) r_state <= OPAD;
                    OPAD: if (!w_first && w_h1_ready && w_h2_ready) r_state <= HMAC;
                    HMAC: if (!w_first && w_h2_ready) r_state <= DONE;
                    DONE: begin
                        r_tag       <= r_mode ? w_h2_digest : {w_h2_digest[511:128], 128'b0};
                        r_tag_valid <= 1'b1;
                        r_state     <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign ready     = (r_state == IDLE);
    assign tag       = r_tag;
    assign tag_valid = r_tag_valid;
    assign error     = r_error;
endmodule

// File: tb/tb_hmac_mode_core.sv
// Self-checking bench for hmac_mode_core: RFC 4231 TC1, error/reset/priority cases and
// randomized init/next sequences against a behavioural HMAC-SHA-384/512 model.

module tb_hmac_mode_core;
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          init = 1'b0;
    logic          next = 1'b0;
    logic          mode = 1'b0;
    logic [511:0]  key = '0;
    logic [1023:0] block = '0;
`ifdef HMAC_ZEROIZE_EN
    logic          zeroize = 1'b0;
`endif
    logic          ready, tag_valid, error;
    logic [511:0]  tag;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [511:0] m_h1;
    logic         m_mode;
    logic [511:0] m_tag;

    hmac_mode_core #(.SUPPORT_512(1)) dut (
`ifdef HMAC_ZEROIZE_EN
        .zeroize   (zeroize),
`endif
        .clk       (clk),
        .reset_n   (reset_n),
        .init      (init),
        .next      (next),
        .mode      (mode),
        .key       (key),
        .block     (block),
        .ready     (ready),
        .tag       (tag),
        .tag_valid (tag_valid),
        .error     (error)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] K [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [511:0] iv_of(input logic m);
        if (m)
            return {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
        return {64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
                64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
    endfunction

    // One SHA-512 compression over a full message schedule
    function automatic logic [511:0] compress(input logic [511:0] hin, input logic [1023:0] blk);
        logic [63:0] w [80];
        logic [63:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[1023-64*t -: 64];
        for (int t = 16; t < 80; t++)
            w[t] = (ror(w[t-2], 19) ^ ror(w[t-2], 61) ^ (w[t-2] >> 6)) + w[t-7]
                 + (ror(w[t-15], 1) ^ ror(w[t-15], 8) ^ (w[t-15] >> 7)) + w[t-16];
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 80; t++) begin
            t1 = h + (ror(e, 14) ^ ror(e, 18) ^ ror(e, 41)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 28) ^ ror(a, 34) ^ ror(a, 39)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[511:448] + a, hin[447:384] + b, hin[383:320] + c, hin[319:256] + d,
                hin[255:192] + e, hin[191:128] + f, hin[127:64] + g, hin[63:0] + h};
    endfunction

    function automatic logic [1023:0] key_block(input logic [511:0] k, input logic m);
        return {(m ? k : {k[511:128], 128'b0}), 512'b0};
    endfunction

    // HMAC outer hash over the inner digest, truncated to 384 bits in mode 0
    function automatic logic [511:0] outer_tag(input logic [511:0] h1, input logic [511:0] k, input logic m);
        logic [511:0]  h2;
        logic [1023:0] fin;
        int            dlen;
        dlen = m ? 64 : 48;
        fin = '0;
        for (int i = 0; i < dlen; i++) fin[1023-8*i -: 8] = h1[511-8*i -: 8];
        fin[1023-8*dlen -: 8] = 8'h80;
        fin[127:0] = 128'((128 + dlen) * 8);
        h2 = compress(compress(iv_of(m), key_block(k, m) ^ {128{8'h5c}}), fin);
        return m ? h2 : {h2[511:128], 128'b0};
    endfunction

    task automatic model_init();
        m_mode = mode;
        m_h1   = compress(compress(iv_of(m_mode), key_block(key, m_mode) ^ {128{8'h36}}), block);
        m_tag  = outer_tag(m_h1, key, m_mode);
    endtask

    task automatic model_next();
        m_h1  = compress(m_h1, block);
        m_tag = outer_tag(m_h1, key, m_mode);
    endtask

    task automatic check_val(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cmd(input logic i, input logic n);
        @(negedge clk);
        init = i;
        next = n;
        @(negedge clk);
        init = 1'b0;
        next = 1'b0;
    endtask

    task automatic wait_ready();
        int cyc = 0;
        while (!ready && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (!ready) check_val("ready_timeout", 512'(ready), 512'd1);
    endtask

    task automatic run_op(input logic i, input logic n, input logic [511:0] exp, input string nm);
        cmd(i, n);
        check_val({nm, "_busy"}, 512'(ready), 512'd0);
        check_val({nm, "_tv_clr"}, 512'(tag_valid), 512'd0);
        wait_ready();
        check_val({nm, "_tag"}, tag, exp);
        check_val({nm, "_tv"}, 512'(tag_valid), 512'd1);
        check_val({nm, "_err"}, 512'(error), 512'd0);
    endtask

    task automatic rand_key_block();
        for (int j = 0; j < 16; j++) key[32*j +: 32] = $urandom();
        for (int j = 0; j < 32; j++) block[32*j +: 32] = $urandom();
    endtask

    task automatic rand_block();
        for (int j = 0; j < 32; j++) block[32*j +: 32] = $urandom();
    endtask

    logic [383:0] tc1_384;
    logic [511:0] tc1_512;

    initial begin
        tc1_384 = 384'hafd03944d84895626b0825f4ab46907f15f9dadbe4101ec682aa034c7cebc59cfaea9ea9076ede7f4af152e8b2fa9cb6;
        tc1_512 = 512'h87aa7cdea5ef619d4ff0b4241a1d6cb02379f4e2ce4ec2787ad0b30545e17cdedaa833b7d6b8a702038b274eaea3f4e4be9d914eeb61f1702e696c203a126854;

        repeat (3) @(negedge clk);
        check_val("rst_ready", 512'(ready), 512'd1);
        check_val("rst_tag", tag, '0);
        check_val("rst_tv", 512'(tag_valid), 512'd0);
        check_val("rst_err", 512'(error), 512'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_ready", 512'(ready), 512'd1);

        // next with no key loaded
        cmd(1'b0, 1'b1);
        check_val("nokey_err", 512'(error), 512'd1);
        check_val("nokey_ready", 512'(ready), 512'd1);
        check_val("nokey_tv", 512'(tag_valid), 512'd0);
        @(negedge clk);
        check_val("nokey_err_pulse", 512'(error), 512'd0);
        check_val("nokey_tag", tag, '0);

        // RFC 4231 test case 1
        key = '0;
        key[511:352] = {20{8'h0b}};
        block = '0;
        block[1023:960] = 64'h4869205468657265;
        block[959:952] = 8'h80;
        block[127:0] = 128'h440;
        mode = 1'b0;
        model_init();
        run_op(1'b1, 1'b0, m_tag, "tc1_384_model");
        check_val("tc1_384_hi", 512'(tag[511:128]), 512'(tc1_384));
        check_val("tc1_384_lo", 512'(tag[127:0]), '0);
        mode = 1'b1;
        model_init();
        run_op(1'b1, 1'b0, tc1_512, "tc1_512");

        // init and next together: init wins
        rand_key_block();
        mode = 1'b1;
        model_init();
        run_op(1'b1, 1'b1, m_tag, "init_next");

        // mode toggled before next keeps the latched HMAC-384
        rand_key_block();
        mode = 1'b0;
        model_init();
        run_op(1'b1, 1'b0, m_tag, "m384_init");
        mode = 1'b1;
        rand_block();
        model_next();
        run_op(1'b0, 1'b1, m_tag, "m384_next");
        check_val("m384_next_lo", 512'(tag[127:0]), '0);

        for (int it = 0; it < 5; it++) begin
            rand_key_block();
            mode = 1'($urandom_range(1, 0));
            model_init();
            run_op(1'b1, 1'b0, m_tag, "rnd_init");
            for (int nb = 0; nb < 2; nb++) begin
                rand_block();
                mode = 1'($urandom_range(1, 0));
                model_next();
                run_op(1'b0, 1'b1, m_tag, "rnd_next");
            end
        end

        // reset in the outer-hash phase
        rand_key_block();
        mode = 1'b1;
        cmd(1'b1, 1'b0);
        repeat (200) @(negedge clk);
        check_val("mid_busy", 512'(ready), 512'd0);
        reset_n = 1'b0;
        @(negedge clk);
        check_val("mid_rst_ready", 512'(ready), 512'd1);
        check_val("mid_rst_tag", tag, '0);
        check_val("mid_rst_tv", 512'(tag_valid), 512'd0);
        reset_n = 1'b1;
        @(negedge clk);
        cmd(1'b0, 1'b1);
        check_val("mid_rst_nokey_err", 512'(error), 512'd1);

`ifdef HMAC_ZEROIZE_EN
        rand_key_block();
        mode = 1'b0;
        model_init();
        run_op(1'b1, 1'b0, m_tag, "zz_pre");
        cmd(1'b1, 1'b0);
        repeat (100) @(negedge clk);
        check_val("zz_busy", 512'(ready), 512'd0);
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        check_val("zz_ready", 512'(ready), 512'd1);
        check_val("zz_tv", 512'(tag_valid), 512'd0);
        check_val("zz_tag", tag, '0);
        cmd(1'b0, 1'b1);
        check_val("zz_nokey_err", 512'(error), 512'd1);
        rand_key_block();
        mode = 1'b1;
        model_init();
        run_op(1'b1, 1'b0, m_tag, "zz_post");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
